// File: rtl/operand_skew_feeder.sv
// ---------------------------------------------------------------------------
// operand_skew_feeder
//
// Buffers up to DIM operand vectors, then streams them diagonally into a
// DIM-lane systolic MAC array. Lane i is delayed by i beats, so on beat t
// lane i carries element i of row (t - i). Once the last diagonal has left,
// a single done pulse is issued and the buffer count is cleared.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   synchronous active-low reset
//   wr_en     in   write wr_data into the next free row (IDLE only)
//   wr_data   in   DIM*BITS_AB operand vector, element j at [j*BITS_AB +: BITS_AB]
//   start     in   begin streaming the buffered rows (IDLE, count > 0)
//   en_out    out  high on every beat that drives the MAC array
//   lane_out  out  skewed operands, lane i at [i*BITS_AB +: BITS_AB]
//   count     out  number of rows currently buffered
//   busy      out  high while streaming
//   done      out  one-cycle pulse after the final beat
// ---------------------------------------------------------------------------
module operand_skew_feeder #(
  parameter int DIM     = 4,
  parameter int BITS_AB = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DIM*BITS_AB-1:0]   wr_data,
  input  logic                     start,
  output logic                     en_out,
  output logic [DIM*BITS_AB-1:0]   lane_out,
  output logic [$clog2(DIM):0]     count,
  output logic                     busy,
  output logic                     done
);

  // The beat counter never exceeds 2*DIM-2, which always fits in the same
  // width as count.
  localparam int CW = $clog2(DIM) + 1;
  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int VW = DIM * BITS_AB;
  localparam logic [CW-1:0] DIM_CNT = CW'(DIM);
  localparam logic [CW-1:0] DIM_M1  = CW'(DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   t_reg, t_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [VW-1:0]   row_reg  [DIM];
  logic [VW-1:0]   row_next [DIM];
  logic            en_reg, en_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic [CW-1:0]   last_t;

  // Index of the final beat: count + DIM - 2.
  assign last_t = count_reg + DIM_M1 - CW'(1);

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    count_next = count_reg;
    row_next   = row_reg;
    en_next    = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (wr_en && (count_reg < DIM_CNT)) begin
          row_next[count_reg[AW-1:0]] = wr_data;
          count_next                  = count_reg + CW'(1);
        end
        // Test against the post-write count so a same-edge write is both
        // accepted and included in the stream.
        if (start && (count_next != '0)) begin
          state_next = ST_STREAM;
          t_next     = '0;
          en_next    = 1'b1;
          busy_next  = 1'b1;
        end
      end

      ST_STREAM: begin
        if (t_reg == last_t) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          t_next    = t_reg + CW'(1);
          en_next   = 1'b1;
          busy_next = 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        count_next = '0;
        t_next     = '0;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      t_reg     <= '0;
      count_reg <= '0;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      for (int r = 0; r < DIM; r++) begin
        row_reg[r] <= '0;
      end
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      count_reg <= count_next;
      en_reg    <= en_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      for (int r = 0; r < DIM; r++) begin
        row_reg[r] <= row_next[r];
      end
    end
  end

  // Per-lane diagonal select. Each lane computes the value for the beat
  // that will be shown after the coming edge (t_next), using the buffer
  // contents as they will be after that edge, so the output register holds
  // exactly the beat currently on the bus.
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_lane
      localparam logic [CW-1:0] LANE = CW'(gi);

      logic [CW-1:0]      diff;
      logic               hit;
      logic [BITS_AB-1:0] lane_val;
      logic [BITS_AB-1:0] lane_reg;

      always_comb begin
        diff     = t_next - LANE;
        hit      = (t_next >= LANE) && (diff < count_next);
        lane_val = '0;
        if (hit) begin
          lane_val = row_next[diff[AW-1:0]][gi*BITS_AB +: BITS_AB];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          lane_reg <= '0;
        end else begin
          lane_reg <= en_next ? lane_val : '0;
        end
      end

      assign lane_out[gi*BITS_AB +: BITS_AB] = lane_reg;
    end
  endgenerate

  assign en_out = en_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign count  = count_reg;

endmodule

// File: doc/operand_skew_feeder.md
OPERAND_SKEW_FEEDER -- requirements
Module: operand_skew_feeder

Interface
REQ-001 SHALL provide parameter DIM, default 4, giving the number of lanes (array rows) and the row-buffer depth.
REQ-002 SHALL provide parameter BITS_AB, default 8, giving the signed operand width per lane.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port wr_en  input  1  write one operand vector into the row buffer.
REQ-006 SHALL have port wr_data  input  DIM*BITS_AB  operand vector; element j occupies bits [j*BITS_AB +: BITS_AB].
REQ-007 SHALL have port start  input  1  request to stream the buffered vectors.
REQ-008 SHALL have port en_out  output  1  high on every cycle the lane outputs drive the MAC array (tpumac en).
REQ-009 SHALL have port lane_out  output  DIM*BITS_AB  skewed operands; lane i occupies bits [i*BITS_AB +: BITS_AB].
REQ-010 SHALL have port count  output  log2(DIM)+1  number of vectors currently buffered.
REQ-011 SHALL have port busy  output  1  high while in STREAM.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last skewed beat.

Function
REQ-013 SHALL implement states IDLE, STREAM and DONE.
REQ-014 In IDLE, a wr_en pulse with count<DIM SHALL store wr_data at row[count] and increment count.
REQ-015 In IDLE, a wr_en pulse with count==DIM SHALL be dropped, leaving buffer and count unchanged.
REQ-016 In IDLE, start with count>0 SHALL move the block to STREAM on the next edge and clear the beat counter t to 0.
REQ-017 In IDLE, start with count==0 SHALL be ignored.
REQ-018 When wr_en and start are sampled on the same edge in IDLE, the write SHALL be accepted if not full, and that vector SHALL be included in the stream.
REQ-019 In STREAM, each cycle SHALL drive en_out=1, busy=1, with lane i = row[t-i][element i] when 0<=t-i<count, else 0.
REQ-020 In STREAM, t SHALL increment by 1 each cycle.
REQ-021 STREAM SHALL last exactly count+DIM-1 cycles, then transition to DONE.
REQ-022 In DONE, the block SHALL drive done=1 for one cycle, en_out=0 and lane_out=0, clear count to 0, and return to IDLE.
REQ-023 In STREAM, wr_en and start SHALL be ignored, and the buffer and count SHALL be frozen.
REQ-024 Outputs en_out, lane_out, busy and done SHALL be registered, so the first skewed beat appears on the cycle after the edge that sampled start.
REQ-025 Operand values SHALL pass through unmodified, with no sign extension, truncation or arithmetic.
REQ-026 In IDLE, en_out, busy and done SHALL be 0, and lane_out SHALL be 0.

Reset
REQ-027 rst_n sampled low at a rising edge SHALL force IDLE and clear count, t, all row-buffer entries, en_out, busy, done and lane_out to 0 after that edge.
REQ-028 Reset asserted mid-STREAM SHALL abort the stream immediately, with no done pulse.
REQ-029 Reset SHALL take priority over wr_en and start sampled on the same edge.
REQ-030 Behaviour SHALL be identical whether rst_n is held low for one cycle or for many cycles.

Verification (DIM=4, BITS_AB=8; row r element j = 10*r+j)
REQ-031 Write 4 rows, pulse start -> en_out high for 7 cycles; lane0 sequence 0,10,20,30,0,0,0; lane3 sequence 0,0,0,3,13,23,33; done pulses on the 8th cycle; count then reads 0.
REQ-032 Write 1 row (values -1,-2,-3,-4), then start -> 4 beats, with lane i = -(i+1) only at beat i (0xFF,0xFE,0xFD,0xFC), all other lane values 0.
REQ-033 Write 5 rows -> count==4; the 5th row is absent from the stream; start with count 0 after done -> no en_out.
REQ-034 In the same cycle, wr_en (row 2) and start with count==2 -> stream of 3 rows, 6 beats.
REQ-035 Assert rst_n low at beat 3 of a 4-row stream -> next cycle en_out=0, busy=0, count=0, no done; a following start is ignored.
REQ-036 Pulse wr_en and start during STREAM -> stream unaffected, beat count unchanged, buffer contents unchanged.
